// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Receives a byte stream over a valid/ready link:
//   [count N] [N little-endian 32-bit words, 4 bytes each] [XOR checksum]
// assembles the words and writes them into instruction memory through a
// dedicated write port. The CPU is held in reset until a load finishes with
// a matching checksum.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active-low
//   rx_valid     byte available on rx_data
//   rx_data      stream byte
//   rx_ready     loader accepts a byte this cycle
//   restart      single-cycle pulse; starts a new load from DONE or ERR
//   imem_we      imem write strobe, one cycle per word
//   imem_addr    imem word address
//   imem_wdata   word to write
//   cpu_hold     1 = CPU held in reset
//   done         load completed with good checksum
//   err          load aborted
//   err_code     00 none, 01 size error, 10 checksum error
//   words_loaded words written in the current load
//   dbg_state    current FSM state (observation only)
//
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both 1. While rx_ready is 0 the source must hold rx_valid/rx_data
// stable; nothing is consumed.
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_loaded,
   output logic [2:0]        dbg_state
);

   localparam logic [2:0] ST_COUNT = 3'd0;
   localparam logic [2:0] ST_DATA  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_CSUM  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd5;

   localparam logic [7:0]    MAX_N   = 8'(IMEM_DEPTH);
   localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [7:0]        acc_q, acc_d;
   logic              rx_ready_q, rx_ready_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

   logic accept;
   logic last_word;

   assign accept    = rx_valid & rx_ready_q;
   // Word index is compared one-wider so N=IMEM_DEPTH is reachable.
   assign last_word = (({1'b0, word_idx_q} + ONE_W) == n_q);

   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      word_idx_d     = word_idx_q;
      byte_idx_d     = byte_idx_q;
      word_d         = word_q;
      acc_d          = acc_q;
      rx_ready_d     = rx_ready_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      cpu_hold_d     = cpu_hold_q;
      done_d         = done_q;
      err_d          = err_q;
      err_code_d     = err_code_q;
      words_loaded_d = words_loaded_q;

      case (state_q)
         ST_COUNT: begin
            if (accept) begin
               n_d = rx_data[ADDR_W:0];
               if (rx_data == 8'd0) begin
                  state_d    = ST_DONE;
                  rx_ready_d = 1'b0;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else if (rx_data > MAX_N) begin
                  state_d    = ST_ERR;
                  rx_ready_d = 1'b0;
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end else begin
                  state_d    = ST_DATA;
                  word_idx_d = '0;
                  byte_idx_d = 2'd0;
               end
            end
         end

         ST_DATA: begin
            if (accept) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               acc_d      = acc_q ^ rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  // Registered outputs: the write strobe is visible in the
                  // WRITE cycle, i.e. the cycle after the 4th byte.
                  state_d        = ST_WRITE;
                  rx_ready_d     = 1'b0;
                  imem_we_d      = 1'b1;
                  imem_addr_d    = word_idx_q;
                  imem_wdata_d   = word_d;
                  words_loaded_d = words_loaded_q + ONE_W;
               end
            end
         end

         ST_WRITE: begin
            rx_ready_d = 1'b1;
            if (last_word) begin
               state_d = ST_CSUM;
            end else begin
               state_d    = ST_DATA;
               word_idx_d = word_idx_q + 1'b1;
            end
         end

         ST_CSUM: begin
            if (accept) begin
               rx_ready_d = 1'b0;
               if (rx_data == acc_q) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d    = ST_ERR;
                  err_d      = 1'b1;
                  err_code_d = 2'b10;
               end
            end
         end

         ST_DONE, ST_ERR: begin
            if (restart) begin
               state_d        = ST_COUNT;
               rx_ready_d     = 1'b1;
               done_d         = 1'b0;
               err_d          = 1'b0;
               err_code_d     = 2'b00;
               words_loaded_d = '0;
               acc_d          = 8'd0;
               cpu_hold_d     = 1'b1;
            end
         end

         default: begin
            state_d    = ST_COUNT;
            rx_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_COUNT;
         n_q            <= '0;
         word_idx_q     <= '0;
         byte_idx_q     <= 2'd0;
         word_q         <= 32'd0;
         acc_q          <= 8'd0;
         rx_ready_q     <= 1'b1;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= 32'd0;
         cpu_hold_q     <= 1'b1;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= 2'b00;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         word_idx_q     <= word_idx_d;
         byte_idx_q     <= byte_idx_d;
         word_q         <= word_d;
         acc_q          <= acc_d;
         rx_ready_q     <= rx_ready_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         cpu_hold_q     <= cpu_hold_d;
         done_q         <= done_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign rx_ready     = rx_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign err          = err_q;
   assign err_code     = err_code_q;
   assign words_loaded = words_loaded_q;
   assign dbg_state    = state_q;

endmodule
